// File: rtl/l1_scratchpad_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | l1_scratchpad_responder                                                    |
// | Single-port scratchpad RAM answering L1 requests: byte-enabled writes,     |
// | critical-word-first read bursts and LR/SC reservation.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module l1_scratchpad_responder #(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        request_valid,
   output logic        request_ack,
   input  logic [29:0] addr,
   input  logic [31:0] data,
   input  logic        rnw,
   input  logic [3:0]  be,
   input  logic [2:0]  size,
   input  logic        con,
   output logic [31:0] rd_data,
   output logic        rd_data_valid,
   output logic        sc_valid,
   output logic        sc_success
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [0:0] {
      IDLE       = 1'b0,
      READ_BURST = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] base_q, base_d;
   logic [2:0]    size_q, size_d;
   logic [2:0]    beat_q, beat_d;
   logic          rd_valid_q, rd_valid_d;
   logic [31:0]   rd_data_q;
   logic          res_valid_q, res_valid_d;
   logic [29:0]   res_addr_q, res_addr_d;
   logic          sc_valid_q, sc_valid_d;
   logic          sc_success_q, sc_success_d;

   logic          ack;
   logic          accept;
   logic          sc_match;
   logic          wr_en;
   logic          fetch_en;
   logic [AW-1:0] fetch_base;
   logic [2:0]    fetch_size;
   logic [2:0]    fetch_beat;
   logic [AW-1:0] fetch_idx;

   logic [31:0]   mem_q [DEPTH_WORDS];

   // Critical-word-first: wrap inside the block aligned to the burst length mask.
   function automatic logic [AW-1:0] beat_index(input logic [AW-1:0] base,
                                                input logic [2:0]    s,
                                                input logic [2:0]    i);
      logic [AW-1:0] smask;
      smask = AW'(s);
      return (base & ~smask) | ((base + AW'(i)) & smask);
   endfunction

   always_comb begin
      ack          = ~rst & ((state_q == IDLE) | (beat_q == size_q));
      accept       = request_valid & ack;
      sc_match     = res_valid_q & (res_addr_q == addr);
      state_d      = state_q;
      base_d       = base_q;
      size_d       = size_q;
      beat_d       = beat_q;
      rd_valid_d   = 1'b0;
      res_valid_d  = res_valid_q;
      res_addr_d   = res_addr_q;
      sc_valid_d   = 1'b0;
      sc_success_d = sc_success_q;
      wr_en        = 1'b0;
      fetch_en     = 1'b0;
      fetch_base   = base_q;
      fetch_size   = size_q;
      fetch_beat   = beat_q + 3'd1;

      if (state_q == READ_BURST) begin
         if (beat_q != size_q) begin
            fetch_en   = 1'b1;
            rd_valid_d = 1'b1;
            beat_d     = beat_q + 3'd1;
         end else begin
            state_d = IDLE;
         end
      end

      if (accept) begin
         if (rnw) begin
            fetch_en   = 1'b1;
            rd_valid_d = 1'b1;
            fetch_base = addr[AW-1:0];
            fetch_size = con ? 3'd0 : size;
            fetch_beat = 3'd0;
            base_d     = addr[AW-1:0];
            size_d     = fetch_size;
            beat_d     = 3'd0;
            state_d    = (fetch_size == 3'd0) ? IDLE : READ_BURST;
            if (con) begin
               res_valid_d = 1'b1;
               res_addr_d  = addr;
            end
         end else begin
            state_d = IDLE;
            if (con) begin
               wr_en        = sc_match;
               sc_valid_d   = 1'b1;
               sc_success_d = sc_match;
               res_valid_d  = 1'b0;
            end else begin
               wr_en = 1'b1;
               if (addr == res_addr_q) begin
                  res_valid_d = 1'b0;
               end
            end
         end
      end

      fetch_idx = beat_index(fetch_base, fetch_size, fetch_beat);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         base_q       <= '0;
         size_q       <= '0;
         beat_q       <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         res_valid_q  <= 1'b0;
         res_addr_q   <= '0;
         sc_valid_q   <= 1'b0;
         sc_success_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         size_q       <= size_d;
         beat_q       <= beat_d;
         rd_valid_q   <= rd_valid_d;
         res_valid_q  <= res_valid_d;
         res_addr_q   <= res_addr_d;
         sc_valid_q   <= sc_valid_d;
         sc_success_q <= sc_success_d;
         if (fetch_en) begin
            rd_data_q <= mem_q[fetch_idx];
         end
      end
   end

   // Non-blocking write beside a same-edge read yields the pre-write word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
               mem_q[addr[AW-1:0]][8*l +: 8] <= data[8*l +: 8];
            end
         end
      end
   end

   assign request_ack   = ack;
   assign rd_data       = rst ? 32'd0 : rd_data_q;
   assign rd_data_valid = rd_valid_q & ~rst;
   assign sc_valid      = sc_valid_q & ~rst;
   assign sc_success    = sc_success_q & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_l1_scratchpad_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_l1_scratchpad_responder                                                 |
// | Directed and randomized checks against a transaction-level scratchpad model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_l1_scratchpad_responder;

   localparam int unsigned DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        request_valid = 1'b0;
   logic        request_ack;
   logic [29:0] addr = '0;
   logic [31:0] data = '0;
   logic        rnw = 1'b0;
   logic [3:0]  be = '0;
   logic [2:0]  size = '0;
   logic        con = 1'b0;
   logic [31:0] rd_data;
   logic        rd_data_valid;
   logic        sc_valid;
   logic        sc_success;

   l1_scratchpad_responder #(.DEPTH_WORDS(DEPTH)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .request_valid (request_valid),
      .request_ack   (request_ack),
      .addr          (addr),
      .data          (data),
      .rnw           (rnw),
      .be            (be),
      .size          (size),
      .con           (con),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .sc_valid      (sc_valid),
      .sc_success    (sc_success)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;

   // Model: memory image, beats still owed after the one on the bus, reservation.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] pend [$];
   logic [31:0] m_rd   = '0;
   logic        m_rdv  = 1'b0;
   logic        m_scv  = 1'b0;
   logic        m_scs  = 1'b0;
   logic        m_resv = 1'b0;
   logic [29:0] m_resa = '0;

   logic [31:0] obs_rd;
   logic        obs_ack, obs_scv, obs_scs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned beat_word(input int unsigned a, input int unsigned s,
                                             input int unsigned i);
      return ((a & ~s) | ((a + i) & s)) % DEPTH;
   endfunction

   task automatic write_mem(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
      int unsigned w;
      w = int'(a) % DEPTH;
      for (int l = 0; l < 4; l++) begin
         if (b[l]) m_mem[w][8*l +: 8] = d[8*l +: 8];
      end
   endtask

   task automatic step(input logic r, input logic v, input logic rw, input logic c,
                       input logic [29:0] a, input logic [31:0] d, input logic [3:0] b,
                       input logic [2:0] s);
      logic exp_ack;
      int   n;
      @(negedge clk);
      rst = r; request_valid = v; rnw = rw; con = c;
      addr = a; data = d; be = b; size = s;
      #1;
      exp_ack = !r && (pend.size() == 0);
      check("ack", 32'(request_ack), 32'(exp_ack));
      check("rd_valid", 32'(rd_data_valid), r ? 32'd0 : 32'(m_rdv));
      check("rd_data", rd_data, r ? 32'd0 : m_rd);
      check("sc_valid", 32'(sc_valid), r ? 32'd0 : 32'(m_scv));
      if (r || m_scv) check("sc_success", 32'(sc_success), r ? 32'd0 : 32'(m_scs));
      obs_rd = rd_data; obs_ack = request_ack; obs_scv = sc_valid; obs_scs = sc_success;

      if (r) begin
         pend.delete();
         m_rdv = 1'b0; m_rd = '0; m_scv = 1'b0; m_scs = 1'b0; m_resv = 1'b0;
      end else begin
         m_scv = 1'b0;
         if (v && exp_ack) begin
            if (rw) begin
               n = c ? 1 : int'(s) + 1;
               for (int i = 0; i < n; i++)
                  pend.push_back(m_mem[beat_word(int'(a), c ? 0 : int'(s), i)]);
               if (c) begin m_resv = 1'b1; m_resa = a; end
            end else if (c) begin
               m_scv = 1'b1;
               m_scs = m_resv && (m_resa == a);
               if (m_scs) write_mem(a, d, b);
               m_resv = 1'b0;
            end else begin
               write_mem(a, d, b);
               if (m_resa == a) m_resv = 1'b0;
            end
         end
         if (pend.size() > 0) begin
            m_rd = pend.pop_front();
            m_rdv = 1'b1;
         end else begin
            m_rdv = 1'b0;
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
      step(1'b0, 1'b1, 1'b0, 1'b0, a, d, b, 3'd0);
   endtask

   task automatic rd(input logic [29:0] a, input logic [2:0] s);
      step(1'b0, 1'b1, 1'b1, 1'b0, a, '0, '0, s);
   endtask

   task automatic lr(input logic [29:0] a);
      step(1'b0, 1'b1, 1'b1, 1'b1, a, '0, '0, 3'd5);
   endtask

   task automatic sc(input logic [29:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, 1'b0, 1'b1, a, d, 4'hF, 3'd0);
   endtask

   task automatic do_rst();
      step(1'b1, 1'b1, 1'b0, 1'b0, 30'h3, 32'hBAD0BAD0, 4'hF, 3'd0);
   endtask

   initial begin
      logic [31:0] exp_beats [8];
      for (int i = 0; i < 3; i++) do_rst();
      for (int w = 0; w < int'(DEPTH); w++) wr(30'(w), $urandom, 4'hF);

      wr(30'h10, 32'hDEADBEEF, 4'hF);
      rd(30'h10, 3'd0);
      idle();
      check("single_read", obs_rd, 32'hDEADBEEF);
      check("single_ack", 32'(obs_ack), 32'd1);

      wr(30'h4, 32'h11223344, 4'hF);
      wr(30'h4, 32'hAABBCCDD, 4'b0101);
      rd(30'h4, 3'd0);
      idle();
      check("byte_enable", obs_rd, 32'h11BB33DD);

      for (int w = 8; w < 16; w++) wr(30'(w), 32'(w), 4'hF);
      exp_beats = '{32'd13, 32'd14, 32'd15, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
      rd(30'd13, 3'd7);
      for (int i = 0; i < 8; i++) begin
         idle();
         check("wrap_beat", obs_rd, exp_beats[i]);
         check("wrap_ack", 32'(obs_ack), (i == 7) ? 32'd1 : 32'd0);
      end

      lr(30'h20);
      sc(30'h20, 32'h5);
      idle();
      check("sc_ok_valid", 32'(obs_scv), 32'd1);
      check("sc_ok_result", 32'(obs_scs), 32'd1);
      sc(30'h20, 32'h6);
      rd(30'h20, 3'd0);
      check("sc_again_result", 32'(obs_scs), 32'd0);
      idle();
      check("sc_word", obs_rd, 32'h5);

      lr(30'h20);
      wr(30'h20, 32'h77, 4'hF);
      sc(30'h20, 32'h99);
      idle();
      check("sc_after_wr", 32'(obs_scs), 32'd0);
      lr(30'h20);
      do_rst();
      sc(30'h20, 32'h99);
      idle();
      check("sc_after_rst", 32'(obs_scs), 32'd0);

      rd(30'd3, 3'd7);
      idle();
      idle();
      do_rst();
      check("rst_burst_ack", 32'(obs_ack), 32'd0);
      idle();
      check("post_rst_ack", 32'(obs_ack), 32'd1);
      idle();
      rd(30'd8, 3'd7);
      for (int i = 0; i < 9; i++) idle();

      // Back-to-back single reads and a request in the final-beat cycle.
      for (int i = 0; i < 6; i++) rd(30'(i * 3), 3'd0);
      rd(30'd40, 3'd3);
      idle(); idle(); idle();
      wr(30'd41, 32'hCAFEF00D, 4'hF);
      rd(30'd41, 3'd0);
      idle();

      for (int i = 0; i < 3000; i++) begin
         logic [29:0] a;
         a = ($urandom_range(0, 3) == 0) ? 30'($urandom_range(0, 127)) : 30'($urandom_range(32, 35));
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
              ($urandom_range(0, 4) == 0), a, $urandom, 4'($urandom), 3'($urandom));
      end
      for (int i = 0; i < 10; i++) idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l1_scratchpad_responder.md
L1_SCRATCHPAD_RESPONDER -- requirements
Module: l1_scratchpad_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, scratchpad size in 32-bit words (power of two, >= 8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port request_valid  input  1  L1 request present.
REQ-005 SHALL have port request_ack  output  1  request accepted this cycle when request_valid=1.
REQ-006 SHALL have port addr  input  30  word address (byte address bits 31:2).
REQ-007 SHALL have port data  input  32  write data.
REQ-008 SHALL have port rnw  input  1  1=read, 0=write.
REQ-009 SHALL have port be  input  4  byte enables; be[i] enables bits 8i+7:8i.
REQ-010 SHALL have port size  input  3  read burst length minus one (0..7).
REQ-011 SHALL have port con  input  1  conditional: LR when rnw=1, SC when rnw=0.
REQ-012 SHALL have port rd_data  output  32  read beat data.
REQ-013 SHALL have port rd_data_valid  output  1  rd_data holds a valid beat.
REQ-014 SHALL have port sc_valid  output  1  SC result present (one-cycle pulse).
REQ-015 SHALL have port sc_success  output  1  SC result; meaningful only when sc_valid=1.

Function
REQ-016 SHALL store words in an internal RAM indexed by addr modulo DEPTH_WORDS; RAM contents are not reset.
REQ-017 SHALL use states IDLE and READ_BURST; handshake completes in cycle N when request_valid=1 and request_ack=1.
REQ-018 SHALL drive request_ack=1 in IDLE, and in READ_BURST only during the cycle the final beat is on rd_data; otherwise 0.
REQ-019 Accepted plain write (rnw=0, con=0) SHALL update enabled byte lanes at the accepting edge, stay in IDLE, ignore size.
REQ-020 Accepted read (rnw=1, con=0) with size=S SHALL present S+1 beats on consecutive cycles N+1..N+1+S, rd_data_valid=1 for each; no gaps.
REQ-021 Beat i (0..S) SHALL read word index (addr & ~S) | ((addr + i) & S), i.e. critical-word-first wrap within the aligned block; non-power-of-two-minus-one S uses the same formula.
REQ-022 S=0 SHALL not leave IDLE; back-to-back single reads SHALL sustain one accept and one beat per cycle.
REQ-023 A request accepted in the final-beat cycle SHALL start immediately (its first beat/write effect follows with no bubble).
REQ-024 LR (rnw=1, con=1) SHALL perform a single-word read (size ignored) and set reservation_valid=1, reservation_addr=addr (overwriting any prior reservation).
REQ-025 SC (rnw=0, con=1) SHALL write with be only if reservation_valid=1 and reservation_addr==addr; cycle N+1 sc_valid=1, sc_success=match; reservation cleared in all cases.
REQ-026 Plain write whose addr equals reservation_addr SHALL clear reservation_valid.
REQ-027 rd_data_valid=0 cycles SHALL hold rd_data at its last value; sc_valid SHALL be 0 except per REQ-025.
REQ-028 A write and a same-address read beat in the same cycle SHALL return the pre-write word (read-before-write).

Reset
REQ-029 While rst=1: state IDLE, request_ack=0, rd_data_valid=0, rd_data=0, sc_valid=0, sc_success=0, reservation_valid=0, burst counter 0.
REQ-030 rst asserted mid-burst SHALL abort: no further beats; request_ack=1 in the first cycle after rst deasserts.
REQ-031 Requests presented while rst=1 SHALL be ignored, including RAM writes.

Verification
REQ-032 Write 0xDEADBEEF, addr 0x10, be=4'hF; read addr 0x10 size 0 -> next cycle rd_data_valid=1, rd_data=0xDEADBEEF, request_ack stays 1.
REQ-033 Write 0x11223344 then 0xAABBCCDD with be=4'b0101 to addr 0x4; read -> 0x11BB33DD.
REQ-034 Preload words 8..15 with their index; read addr 13 size 7 -> beats 13,14,15,8,9,10,11,12 in cycles N+1..N+8; request_ack=0 in N+1..N+7, 1 in N+8.
REQ-035 LR addr 0x20; SC addr 0x20 data 0x5 -> sc_valid=1, sc_success=1, word=0x5; repeat SC data 0x6 -> sc_success=0, word stays 0x5.
REQ-036 LR addr 0x20; plain write addr 0x20; SC addr 0x20 -> sc_success=0; also SC after rst -> sc_success=0.
REQ-037 Read size 7, assert rst for one cycle at third beat -> rd_data_valid=0 from the reset cycle on; request_ack=1 the cycle after reset; RAM contents intact.
